// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: picks PCSEL/PC_EN/XP_WR each cycle from the opcode, interrupt and memory-stall state.
// Outputs are combinational (zero latency); a memory wait of 256 stall cycles is aborted into an ILLOP trap.
module pc_seq_ctrl (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [5:0] opcode_i,
  input  logic       z_i,
  input  logic       pc31_i,
  input  logic       irq_i,
  input  logic       mem_busy_i,
  output logic [2:0] pcsel_o,
  output logic       pc_en_o,
  output logic       xp_wr_o,
  output logic       irq_ack_o,
  output logic       timeout_o
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [2:0] SEL_INC   = 3'd0;
  localparam logic [2:0] SEL_BR    = 3'd1;
  localparam logic [2:0] SEL_JT    = 3'd2;
  localparam logic [2:0] SEL_ILLOP = 3'd3;
  localparam logic [2:0] SEL_XADR  = 3'd4;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  state_e     state_q, state_d;
  logic       irq_pend_q, irq_pend_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       illegal, mem_op, take_br;

  assign illegal = (opcode_i < 6'h18) || (opcode_i == 6'h1A) || (opcode_i == 6'h1E) ||
                   (opcode_i == 6'h27) || (opcode_i == 6'h2F) || (opcode_i == 6'h37) ||
                   (opcode_i == 6'h3F);
  assign mem_op  = (opcode_i == OP_LD) || (opcode_i == OP_ST) || (opcode_i == OP_LDR);
  assign take_br = ((opcode_i == OP_BEQ) && z_i) || ((opcode_i == OP_BNE) && !z_i);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pcsel_o   = SEL_INC;
    pc_en_o   = 1'b0;
    xp_wr_o   = 1'b0;
    irq_ack_o = 1'b0;
    timeout_o = 1'b0;
    // Outputs are forced low for the whole time reset is asserted, not just at the edge.
    if (reset_n_i) begin
      case (state_q)
        S_RUN: begin
          if (irq_pend_q && !pc31_i) begin
            pcsel_o   = SEL_XADR;
            pc_en_o   = 1'b1;
            xp_wr_o   = 1'b1;
            irq_ack_o = 1'b1;
          end else if (illegal) begin
            pcsel_o = SEL_ILLOP;
            pc_en_o = 1'b1;
            xp_wr_o = 1'b1;
          end else if (mem_op && mem_busy_i) begin
            state_d = S_WAIT;
            wcnt_d  = 8'd0;
          end else begin
            pc_en_o = 1'b1;
            if (take_br) begin
              pcsel_o = SEL_BR;
            end else if (opcode_i == OP_JMP) begin
              pcsel_o = SEL_JT;
            end
          end
        end
        S_WAIT: begin
          if (!mem_busy_i) begin
            pc_en_o = 1'b1;
            state_d = S_RUN;
            wcnt_d  = 8'd0;
          end else if (wcnt_q == 8'hFF) begin
            pcsel_o   = SEL_ILLOP;
            pc_en_o   = 1'b1;
            xp_wr_o   = 1'b1;
            timeout_o = 1'b1;
            state_d   = S_RUN;
            wcnt_d    = 8'd0;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
    // A masked interrupt is simply held: no ack means the pending bit stays set.
    irq_pend_d = irq_i | (irq_pend_q & ~irq_ack_o);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_RUN;
      irq_pend_q <= 1'b0;
      wcnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
      wcnt_q     <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenario tasks plus a randomized run against a cycle-level reference model.
module tb_pc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       z, pc31, irq, busy;
  logic [2:0] pcsel_o;
  logic       pc_en_o, xp_wr_o, irq_ack_o, timeout_o;
  logic [6:0] obs;

  int total = 0;
  int bad   = 0;

  // Reference model state: waiting or not, cycles spent waiting, interrupt pending.
  bit m_wait;
  int m_waited;
  bit m_pend;

  pc_seq_ctrl dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .opcode_i   (opcode),
    .z_i        (z),
    .pc31_i     (pc31),
    .irq_i      (irq),
    .mem_busy_i (busy),
    .pcsel_o    (pcsel_o),
    .pc_en_o    (pc_en_o),
    .xp_wr_o    (xp_wr_o),
    .irq_ack_o  (irq_ack_o),
    .timeout_o  (timeout_o)
  );

  assign obs = {pcsel_o, pc_en_o, xp_wr_o, irq_ack_o, timeout_o};

  always #5 clk = ~clk;

  function automatic bit is_illegal(input logic [5:0] op);
    return (op <= 6'h17) || (op inside {6'h1A, 6'h1E, 6'h27, 6'h2F, 6'h37, 6'h3F});
  endfunction

  function automatic bit is_mem(input logic [5:0] op);
    return op inside {6'h18, 6'h19, 6'h1F};
  endfunction

  // Expected {pcsel, pc_en, xp_wr, irq_ack, timeout} for the current inputs.
  function automatic logic [6:0] model_out();
    logic [2:0] sel;
    logic en, xp, ack, to;
    sel = 3'd0; en = 1'b0; xp = 1'b0; ack = 1'b0; to = 1'b0;
    if (rst_n === 1'b1) begin
      if (!m_wait) begin
        if (m_pend && !pc31) begin
          sel = 3'd4; en = 1'b1; xp = 1'b1; ack = 1'b1;
        end else if (is_illegal(opcode)) begin
          sel = 3'd3; en = 1'b1; xp = 1'b1;
        end else if (!(is_mem(opcode) && busy)) begin
          en = 1'b1;
          if ((opcode == 6'h1C && z) || (opcode == 6'h1D && !z)) sel = 3'd1;
          else if (opcode == 6'h1B) sel = 3'd2;
        end
      end else if (!busy) begin
        en = 1'b1;
      end else if (m_waited == 255) begin
        sel = 3'd3; en = 1'b1; xp = 1'b1; to = 1'b1;
      end
    end
    return {sel, en, xp, ack, to};
  endfunction

  task automatic model_clear();
    m_wait = 1'b0; m_waited = 0; m_pend = 1'b0;
  endtask

  // Advance one clock; the model follows the same edge. Returns 1ns after the edge.
  task automatic tick();
    logic [6:0] e;
    @(posedge clk);
    e = model_out();
    if (rst_n !== 1'b1) begin
      model_clear();
    end else begin
      if (!m_wait) begin
        if (!e[3]) begin m_wait = 1'b1; m_waited = 0; end
      end else if (e[3]) begin
        m_wait = 1'b0; m_waited = 0;
      end else begin
        m_waited++;
      end
      m_pend = irq | (m_pend & !e[1]);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'h20; irq = 1'b1; pc31 = 1'b0; z = 1'b0; busy = 1'b0;
    model_clear();
    tick(); tick(); #1;
    total++;
    if (obs !== 7'b0) begin bad++; $display("FAIL reset_outputs: got %b want %b", obs, 7'b0); end
    rst_n = 1'b1; #1;
    total++;
    if (obs !== {3'd0, 4'b1000}) begin bad++; $display("FAIL release_first_cycle: got %b want %b", obs, {3'd0, 4'b1000}); end
    tick();
    total++;
    if (obs !== {3'd4, 4'b1110}) begin bad++; $display("FAIL release_irq_taken: got %b want %b", obs, {3'd4, 4'b1110}); end
    irq = 1'b0; #1;
    tick();
    total++;
    if (obs !== {3'd0, 4'b1000}) begin bad++; $display("FAIL after_ack_seq: got %b want %b", obs, {3'd0, 4'b1000}); end
  endtask

  task automatic test_branch();
    logic [5:0] ops  [5];
    logic       zs   [5];
    logic [2:0] sels [5];
    ops  = '{6'h1C, 6'h1C, 6'h1D, 6'h1D, 6'h1B};
    zs   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    sels = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd2};
    irq = 1'b0; pc31 = 1'b0; busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      opcode = ops[i]; z = zs[i]; #1;
      total++;
      if (obs !== {sels[i], 4'b1000})
        begin bad++; $display("FAIL branch_%0d op=%h z=%b: got %b want %b", i, ops[i], zs[i], obs, {sels[i], 4'b1000}); end
      tick();
    end
  endtask

  task automatic test_illegal_masked();
    opcode = 6'h27; pc31 = 1'b1; irq = 1'b1; busy = 1'b0; #1;
    total++;
    if (obs !== {3'd3, 4'b1100}) begin bad++; $display("FAIL illegal_kernel: got %b want %b", obs, {3'd3, 4'b1100}); end
    tick();
    total++;
    if (obs !== {3'd3, 4'b1100}) begin bad++; $display("FAIL irq_masked: got %b want %b", obs, {3'd3, 4'b1100}); end
    tick();
    pc31 = 1'b0; #1;
    total++;
    if (obs !== {3'd4, 4'b1110}) begin bad++; $display("FAIL irq_unmasked: got %b want %b", obs, {3'd4, 4'b1110}); end
    irq = 1'b0; #1;
    tick();
    total++;
    if (obs !== {3'd3, 4'b1100}) begin bad++; $display("FAIL illegal_user: got %b want %b", obs, {3'd3, 4'b1100}); end
  endtask

  task automatic test_stall();
    opcode = 6'h18; busy = 1'b1; irq = 1'b0; pc31 = 1'b0; #1;
    total++;
    if (obs !== 7'b0) begin bad++; $display("FAIL stall_entry: got %b want %b", obs, 7'b0); end
    tick();
    for (int i = 0; i < 3; i++) begin
      irq = (i == 1); #1;
      total++;
      if (obs !== 7'b0) begin bad++; $display("FAIL stall_wait_%0d: got %b want %b", i, obs, 7'b0); end
      tick();
    end
    irq = 1'b0; busy = 1'b0; #1;
    total++;
    if (obs !== {3'd0, 4'b1000}) begin bad++; $display("FAIL wait_exit: got %b want %b", obs, {3'd0, 4'b1000}); end
    tick();
    total++;
    if (obs !== {3'd4, 4'b1110}) begin bad++; $display("FAIL irq_after_wait: got %b want %b", obs, {3'd4, 4'b1110}); end
    tick();
    total++;
    if (obs !== {3'd0, 4'b1000}) begin bad++; $display("FAIL seq_after_irq: got %b want %b", obs, {3'd0, 4'b1000}); end
  endtask

  task automatic test_timeout();
    int zeros;
    opcode = 6'h19; busy = 1'b1; irq = 1'b0; pc31 = 1'b0; #1;
    zeros = 0;
    for (int i = 0; i < 256; i++) begin
      if (obs === 7'b0) zeros++;
      tick();
    end
    total++;
    if (zeros != 256) begin bad++; $display("FAIL timeout_stall_cycles: got %0d want %0d", zeros, 256); end
    total++;
    if (obs !== {3'd3, 4'b1101}) begin bad++; $display("FAIL timeout_trap: got %b want %b", obs, {3'd3, 4'b1101}); end
    tick();
    opcode = 6'h1B; busy = 1'b0; #1;
    total++;
    if (obs !== {3'd2, 4'b1000}) begin bad++; $display("FAIL run_after_timeout: got %b want %b", obs, {3'd2, 4'b1000}); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int n;
    opcode = 6'h19; busy = 1'b1; irq = 1'b0; pc31 = 1'b0; #1;
    tick();
    repeat (100) tick();
    rst_n = 1'b0; model_clear(); #1;
    total++;
    if (obs !== 7'b0) begin bad++; $display("FAIL reset_mid_wait: got %b want %b", obs, 7'b0); end
    tick();
    total++;
    if (obs !== 7'b0) begin bad++; $display("FAIL reset_held_wait: got %b want %b", obs, 7'b0); end
    rst_n = 1'b1; #1;
    n = 0;
    while (pc_en_o === 1'b0 && n < 400) begin
      n++;
      tick();
    end
    total++;
    if (n != 256) begin bad++; $display("FAIL wait_restart_len: got %0d want %0d", n, 256); end
    total++;
    if (obs !== {3'd3, 4'b1101}) begin bad++; $display("FAIL wait_restart_trap: got %b want %b", obs, {3'd3, 4'b1101}); end
    busy = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [5:0] picks [12];
    logic [6:0] e;
    int errs;
    picks = '{6'h18, 6'h19, 6'h1F, 6'h1B, 6'h1C, 6'h1D, 6'h1A, 6'h1E, 6'h27, 6'h20, 6'h3F, 6'h30};
    errs = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; model_clear();
      end else begin
        rst_n = 1'b1;
      end
      opcode = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 11)] : 6'($urandom_range(0, 63));
      z    = 1'($urandom_range(0, 1));
      pc31 = ($urandom_range(0, 3) == 0);
      irq  = ($urandom_range(0, 7) == 0);
      busy = ($urandom_range(0, 3) != 0);
      #1;
      e = model_out();
      total++;
      if (obs !== e) begin
        bad++; errs++;
        if (errs <= 10)
          $display("FAIL random_cycle_%0d op=%h z=%b pc31=%b busy=%b: got %b want %b", c, opcode, z, pc31, busy, obs, e);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_branch();
    test_illegal_masked();
    test_stall();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
